// File: rtl/axi_lite_pkg.sv
// rtl/axi_lite_pkg.sv - AXI-Lite response codes and initiator state encoding
package axi_lite_pkg;

    localparam logic [1:0] AXI_OK  = 2'b00;
    localparam logic [1:0] AXI_ERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WR_RESP,
        RD_ADDR,
        RD_DATA,
        RSP
    } state_t;

endpackage

// File: rtl/axi_lite_cfg_master.sv
// rtl/axi_lite_cfg_master.sv - single-outstanding AXI-Lite initiator for register commands
module axi_lite_cfg_master
    import axi_lite_pkg::*;
#(
    parameter int ADDR_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [31:0]           cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic                  rsp_timeout,
    output logic [ADDR_WIDTH-1:0] m_axi_lite_awaddr,
    output logic                  m_axi_lite_awvalid,
    input  logic                  m_axi_lite_awready,
    output logic [31:0]           m_axi_lite_wdata,
    output logic [3:0]            m_axi_lite_wstrb,
    output logic                  m_axi_lite_wvalid,
    input  logic                  m_axi_lite_wready,
    input  logic [1:0]            m_axi_lite_bresp,
    input  logic                  m_axi_lite_bvalid,
    output logic                  m_axi_lite_bready,
    output logic [ADDR_WIDTH-1:0] m_axi_lite_araddr,
    output logic                  m_axi_lite_arvalid,
    input  logic                  m_axi_lite_arready,
    input  logic [31:0]           m_axi_lite_rdata,
    input  logic [1:0]            m_axi_lite_rresp,
    input  logic                  m_axi_lite_rvalid,
    output logic                  m_axi_lite_rready
);

    localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  awvalid_q, awvalid_d, wvalid_q, wvalid_d;
    logic                  arvalid_q, arvalid_d, bready_q, bready_d, rready_q, rready_d;
    logic                  rsp_valid_q, rsp_valid_d, rsp_timeout_q, rsp_timeout_d;
    logic [31:0]           rdata_q, rdata_d;
    logic [1:0]            resp_q, resp_d;
    logic [15:0]           tmo_cnt_q, tmo_cnt_d;
    logic                  tmo_hit, aw_done, w_done;

    assign cmd_ready          = (state_q == IDLE) && !reset;
    assign rsp_valid          = rsp_valid_q;
    assign rsp_rdata          = rdata_q;
    assign rsp_resp           = resp_q;
    assign rsp_timeout        = rsp_timeout_q;
    assign m_axi_lite_awaddr  = addr_q;
    assign m_axi_lite_araddr  = addr_q;
    assign m_axi_lite_wdata   = wdata_q;
    assign m_axi_lite_wstrb   = 4'hF;
    assign m_axi_lite_awvalid = awvalid_q;
    assign m_axi_lite_wvalid  = wvalid_q;
    assign m_axi_lite_arvalid = arvalid_q;
    assign m_axi_lite_bready  = bready_q;
    assign m_axi_lite_rready  = rready_q;

    // The counter is cleared on the accept edge, so expiry lands one cycle after it passes TIMEOUT_CYCLES-1.
    assign tmo_hit = (TIMEOUT_CYCLES != 0) && (tmo_cnt_q == TMO_LIMIT);
    // A channel whose valid has already dropped inside WR has completed its handshake.
    assign aw_done = !awvalid_q || m_axi_lite_awready;
    assign w_done  = !wvalid_q  || m_axi_lite_wready;

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        awvalid_d     = awvalid_q;
        wvalid_d      = wvalid_q;
        arvalid_d     = arvalid_q;
        bready_d      = bready_q;
        rready_d      = rready_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_timeout_d = rsp_timeout_q;
        rdata_d       = rdata_q;
        resp_d        = resp_q;
        tmo_cnt_d     = tmo_cnt_q + 16'd1;
        case (state_q)
            IDLE: begin
                tmo_cnt_d = '0;
                if (cmd_valid && cmd_ready) begin
                    addr_d  = cmd_addr & ~ADDR_WIDTH'(3);
                    wdata_d = cmd_wdata;
                    if (cmd_write) begin
                        state_d   = WR;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = RD_ADDR;
                        arvalid_d = 1'b1;
                    end
                end
            end
            WR: begin
                if (m_axi_lite_awready) awvalid_d = 1'b0;
                if (m_axi_lite_wready)  wvalid_d  = 1'b0;
                if (aw_done && w_done) begin
                    state_d  = WR_RESP;
                    bready_d = 1'b1;
                end else if (tmo_hit) begin
                    state_d = RSP;
                end
            end
            WR_RESP: begin
                if (m_axi_lite_bvalid) begin
                    state_d     = RSP;
                    bready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    resp_d      = m_axi_lite_bresp;
                    rdata_d     = '0;
                end else if (tmo_hit) begin
                    state_d = RSP;
                end
            end
            RD_ADDR: begin
                if (m_axi_lite_arready) begin
                    state_d   = RD_DATA;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end else if (tmo_hit) begin
                    state_d = RSP;
                end
            end
            RD_DATA: begin
                if (m_axi_lite_rvalid) begin
                    state_d     = RSP;
                    rready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    resp_d      = m_axi_lite_rresp;
                    rdata_d     = m_axi_lite_rdata;
                end else if (tmo_hit) begin
                    state_d = RSP;
                end
            end
            RSP: begin
                tmo_cnt_d = tmo_cnt_q;
                if (rsp_ready) begin
                    state_d       = IDLE;
                    rsp_valid_d   = 1'b0;
                    rsp_timeout_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        // Abandon the bus: the transition into RSP from a bus state only happens on expiry here.
        if (state_q != IDLE && state_q != RSP && state_d == RSP && !rsp_valid_d) begin
            awvalid_d     = 1'b0;
            wvalid_d      = 1'b0;
            arvalid_d     = 1'b0;
            bready_d      = 1'b0;
            rready_d      = 1'b0;
            rsp_valid_d   = 1'b1;
            rsp_timeout_d = 1'b1;
            resp_d        = AXI_ERR;
            rdata_d       = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            wdata_q       <= '0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            bready_q      <= 1'b0;
            rready_q      <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
            rdata_q       <= '0;
            resp_q        <= AXI_OK;
            tmo_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            awvalid_q     <= awvalid_d;
            wvalid_q      <= wvalid_d;
            arvalid_q     <= arvalid_d;
            bready_q      <= bready_d;
            rready_q      <= rready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_timeout_q <= rsp_timeout_d;
            rdata_q       <= rdata_d;
            resp_q        <= resp_d;
            tmo_cnt_q     <= tmo_cnt_d;
        end
    end

endmodule

// File: tb/tb_axi_lite_cfg_master.sv
// tb/tb_axi_lite_cfg_master.sv - directed bench with an 8-entry register-file responder
module tb_axi_lite_cfg_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [7:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [7:0]  awaddr, araddr;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    axi_lite_cfg_master #(.ADDR_WIDTH(8), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
        .m_axi_lite_awaddr(awaddr), .m_axi_lite_awvalid(awvalid), .m_axi_lite_awready(awready),
        .m_axi_lite_wdata(wdata), .m_axi_lite_wstrb(wstrb), .m_axi_lite_wvalid(wvalid),
        .m_axi_lite_wready(wready), .m_axi_lite_bresp(bresp), .m_axi_lite_bvalid(bvalid),
        .m_axi_lite_bready(bready), .m_axi_lite_araddr(araddr), .m_axi_lite_arvalid(arvalid),
        .m_axi_lite_arready(arready), .m_axi_lite_rdata(rdata), .m_axi_lite_rresp(rresp),
        .m_axi_lite_rvalid(rvalid), .m_axi_lite_rready(rready)
    );

    // Responder: register file with programmable handshake waits.
    logic [31:0] regs [0:7];
    logic        aw_got, w_got;
    logic [7:0]  aw_a, a_eff, last_awaddr, last_araddr;
    logic [31:0] w_d, d_eff, last_wdata;
    logic [3:0]  last_wstrb;
    int          aw_cnt, w_cnt, aw_wait, w_wait, n_writes;
    bit          b_en, r_en;

    assign awready = awvalid && (aw_cnt >= aw_wait);
    assign wready  = wvalid && (w_cnt >= w_wait);
    assign arready = arvalid;
    assign bresp   = 2'b00;
    assign rresp   = 2'b00;
    assign a_eff   = (awvalid && awready) ? awaddr : aw_a;
    assign d_eff   = (wvalid && wready) ? wdata : w_d;

    always @(posedge clk) begin
        if (reset) begin
            aw_got <= 1'b0; w_got <= 1'b0; bvalid <= 1'b0; rvalid <= 1'b0;
            aw_cnt <= 0; w_cnt <= 0;
        end else begin
            aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
            w_cnt  <= (wvalid && !wready) ? w_cnt + 1 : 0;
            if (awvalid && awready) begin aw_got <= 1'b1; aw_a <= awaddr; last_awaddr <= awaddr; end
            if (wvalid && wready) begin w_got <= 1'b1; w_d <= wdata; last_wdata <= wdata; last_wstrb <= wstrb; end
            if ((aw_got || (awvalid && awready)) && (w_got || (wvalid && wready))) begin
                regs[a_eff[4:2]] <= d_eff;
                n_writes <= n_writes + 1;
                aw_got <= 1'b0;
                w_got  <= 1'b0;
                if (b_en) bvalid <= 1'b1;
            end
            if (bvalid && bready) bvalid <= 1'b0;
            if (arvalid && arready) begin
                last_araddr <= araddr;
                rdata <= regs[araddr[4:2]];
                if (r_en) rvalid <= 1'b1;
            end
            if (rvalid && rready) rvalid <= 1'b0;
        end
    end

    logic [255:0] awv_h, wv_h;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send_cmd(input logic w, input logic [7:0] a, input logic [31:0] d);
        bit ok = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (cmd_ready) begin
                @(posedge clk);
                ok = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        #1 cmd_valid = 1'b0;
        if (!ok) check("cmd_accept_bound", 32'(0), 32'(1));
    endtask

    task automatic wait_rsp(output int k);
        bit found = 1'b0;
        k = -1;
        awv_h = '0; wv_h = '0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            awv_h[i] = awvalid;
            wv_h[i]  = wvalid;
            if (rsp_valid) begin
                found = 1'b1;
                k = i;
            end
        end
        if (!found) check("rsp_wait_bound", 32'(0), 32'(1));
    endtask

    task automatic take_rsp();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    int          k, nw;
    logic [31:0] held;

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b0; aw_wait = 0; w_wait = 0; b_en = 1'b1; r_en = 1'b1; n_writes = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_cmd_ready", 32'(cmd_ready), 32'(0));
        check("reset_valids", 32'({awvalid, wvalid, arvalid, bready, rready}), 32'(0));
        check("reset_rsp", 32'({rsp_valid, rsp_timeout}), 32'(0));
        check("reset_rsp_data", rsp_rdata, 32'(0));
        reset = 1'b0;
        #1 check("post_reset_cmd_ready", 32'(cmd_ready), 32'(1));

        // Zero-wait write then read back with ignored low address bits.
        send_cmd(1'b1, 8'h08, 32'h0000_00E6);
        wait_rsp(k);
        check("wr_latency", 32'(k), 32'(2));
        check("wr_awaddr", 32'(last_awaddr), 32'h08);
        check("wr_wdata", last_wdata, 32'h0000_00E6);
        check("wr_wstrb", 32'(last_wstrb), 32'hF);
        check("wr_resp", 32'(rsp_resp), 32'(0));
        check("wr_timeout", 32'(rsp_timeout), 32'(0));
        check("wr_rdata_zero", rsp_rdata, 32'(0));
        check("wr_count", 32'(n_writes), 32'(1));
        take_rsp();

        send_cmd(1'b0, 8'h0B, 32'h0);
        wait_rsp(k);
        check("rd_araddr_aligned", 32'(last_araddr), 32'h08);
        check("rd_rdata", rsp_rdata, 32'h0000_00E6);
        check("rd_resp", 32'(rsp_resp), 32'(0));
        take_rsp();

        // Address channel accepts three cycles ahead of the data channel.
        w_wait = 3; nw = n_writes;
        send_cmd(1'b1, 8'h04, 32'h1234_5678);
        wait_rsp(k);
        check("stagger_aw_dropped", 32'(awv_h[1]), 32'(0));
        check("stagger_w_held", 32'(wv_h[3]), 32'(1));
        check("stagger_w_dropped", 32'(wv_h[4]), 32'(0));
        check("stagger_one_write", 32'(n_writes - nw), 32'(1));
        check("stagger_resp", 32'(rsp_resp), 32'(0));
        take_rsp();
        w_wait = 0;

        // Response back-pressure: outputs stable, no new command taken.
        send_cmd(1'b0, 8'h04, 32'h0);
        wait_rsp(k);
        held = rsp_rdata;
        check("bp_rdata", held, 32'h1234_5678);
        nw = n_writes;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h0C; cmd_wdata = 32'hAAAA_5555;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_rsp_valid", 32'(rsp_valid), 32'(1));
            check("bp_rdata_stable", rsp_rdata, 32'h1234_5678);
            check("bp_cmd_ready", 32'(cmd_ready), 32'(0));
            check("bp_no_aw", 32'(awvalid), 32'(0));
        end
        cmd_valid = 1'b0;
        take_rsp();
        check("bp_no_write", 32'(n_writes - nw), 32'(0));

        // Responder never answers the write: timeout path.
        b_en = 1'b0;
        send_cmd(1'b1, 8'h10, 32'h55);
        wait_rsp(k);
        check("tmo_first_aw", 32'(awv_h[0]), 32'(1));
        check("tmo_latency", 32'(k), 32'(17));
        check("tmo_bready_dropped", 32'(bready), 32'(0));
        check("tmo_resp", 32'(rsp_resp), 32'(2));
        check("tmo_flag", 32'(rsp_timeout), 32'(1));
        check("tmo_rdata", rsp_rdata, 32'(0));
        take_rsp();
        b_en = 1'b1;
        send_cmd(1'b1, 8'h1C, 32'h77);
        wait_rsp(k);
        check("after_tmo_latency", 32'(k), 32'(2));
        check("after_tmo_resp", 32'(rsp_resp), 32'(0));
        check("after_tmo_flag", 32'(rsp_timeout), 32'(0));
        take_rsp();

        // Reset while waiting for read data.
        r_en = 1'b0;
        send_cmd(1'b0, 8'h08, 32'h0);
        @(negedge clk);
        @(negedge clk);
        check("rst_in_rd_data", 32'(rready), 32'(1));
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_bus_idle", 32'({arvalid, rready, rsp_valid}), 32'(0));
        reset = 1'b0;
        r_en = 1'b1;
        #1 check("rst_cmd_ready", 32'(cmd_ready), 32'(1));
        repeat (3) @(negedge clk);
        check("rst_no_rsp", 32'(rsp_valid), 32'(0));
        send_cmd(1'b0, 8'h08, 32'h0);
        wait_rsp(k);
        check("rst_then_read", rsp_rdata, 32'h0000_00E6);
        take_rsp();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
